mul_sequencer: RTL and testbench

Shared iterative 16x16 multiply engine with a 2-way round-robin arbiter in front of it. It replaces the single-cycle combinational MULU/MULS multiply in the mini ALU datapath. Requester 0 is the ALU execute stage; requester 1 is a secondary master such as a DMA or test port. Each requester gets a 2W-bit product (low/high halves, matching the result/high-part register convention) after a fixed shift-add latency.

---
 rtl/mul_sequencer_pkg.sv | 20 ++
 rtl/mul_sequencer_rr_arbiter2.sv | 24 ++
 rtl/mul_sequencer.sv | 144 ++++++++++++++
 tb/tb_mul_sequencer.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_sequencer_pkg.sv
// Shared types and constants for the iterative multiply sequencer.
package mul_sequencer_pkg;

    localparam int unsigned WIDTH_DEF = 16;

    localparam int unsigned REQ_ALU = 0;
    localparam int unsigned REQ_AUX = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // One-hot requester select from a requester index.
    function automatic logic [1:0] req_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/mul_sequencer_rr_arbiter2.sv
// Two-way round-robin arbiter; grant is combinational and one-hot.
module rr_arbiter2
    import mul_sequencer_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    input  logic       en,
    output logic [1:0] grant
);

    // On a tie the requester that was not served last wins.
    always_comb begin
        grant = 2'b00;
        if (en) begin
            unique case (req)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = req_onehot(~last);
                default: grant = 2'b00;
            endcase
        end
    end

endmodule

// File: rtl/mul_sequencer.sv
// Shared shift-add multiplier (WIDTH x WIDTH -> 2*WIDTH) with a two-way
// round-robin front end. Signed operands are run as magnitudes and the
// product is negated once at the end.
module mul_sequencer
    import mul_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [1:0]       iReq,
    input  logic [1:0]       iSigned,
    input  logic [WIDTH-1:0] iOpA0,
    input  logic [WIDTH-1:0] iOpB0,
    input  logic [WIDTH-1:0] iOpA1,
    input  logic [WIDTH-1:0] iOpB1,
    output logic [1:0]       oGrant,
    output logic             oBusy,
    output logic             oOwner,
    output logic [1:0]       oDone,
    output logic [WIDTH-1:0] oResultLow,
    output logic [WIDTH-1:0] oResultHigh
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t          state_q, state_d;
    logic [1:0]      grant;
    logic            last_q;
    logic            owner_q;
    logic            neg_q;
    logic [PW-1:0]   mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [PW-1:0]   acc_q;
    logic [CW-1:0]   cnt_q;
    logic [1:0]      done_q;
    logic [WIDTH-1:0] res_lo_q, res_hi_q;

    logic            sel_idx;
    logic            sel_sgn;
    logic [WIDTH-1:0] sel_a, sel_b;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic            sel_neg;
    logic            last_step;
    logic [PW-1:0]   acc_sum;
    logic [PW-1:0]   prod_final;

    rr_arbiter2 u_arb (
        .req   (iReq),
        .last  (last_q),
        .en    (state_q == ST_IDLE),
        .grant (grant)
    );

    // Operand select and sign-magnitude conversion for the winning requester.
    always_comb begin
        sel_idx = grant[1];
        sel_a   = sel_idx ? iOpA1 : iOpA0;
        sel_b   = sel_idx ? iOpB1 : iOpB0;
        sel_sgn = iSigned[sel_idx];
        mag_a   = (sel_sgn && sel_a[WIDTH-1]) ? (~sel_a) + WIDTH'(1) : sel_a;
        mag_b   = (sel_sgn && sel_b[WIDTH-1]) ? (~sel_b) + WIDTH'(1) : sel_b;
        sel_neg = sel_sgn & (sel_a[WIDTH-1] ^ sel_b[WIDTH-1]);
    end

    // One shift-add step and the sign-corrected product of the final step.
    always_comb begin
        last_step  = (cnt_q == CW'(WIDTH - 1));
        acc_sum    = acc_q + (mplier_q[0] ? mcand_q : '0);
        prod_final = neg_q ? (~acc_sum) + PW'(1) : acc_sum;
    end

    // State register.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: IDLE -> RUN on a grant, RUN -> DONE after WIDTH steps.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (|grant)   state_d = ST_RUN;
            ST_RUN:  if (last_step) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Capture, iterate and publish the product.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            last_q   <= 1'(REQ_AUX);
            owner_q  <= 1'b0;
            neg_q    <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            done_q   <= 2'b00;
            res_lo_q <= '0;
            res_hi_q <= '0;
        end else begin
            done_q <= 2'b00;
            unique case (state_q)
                ST_IDLE: begin
                    if (|grant) begin
                        owner_q  <= sel_idx;
                        last_q   <= sel_idx;
                        neg_q    <= sel_neg;
                        mcand_q  <= PW'(mag_a);
                        mplier_q <= mag_b;
                        acc_q    <= '0;
                        cnt_q    <= '0;
                    end
                end
                ST_RUN: begin
                    acc_q    <= acc_sum;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + CW'(1);
                    if (last_step) begin
                        res_lo_q <= prod_final[WIDTH-1:0];
                        res_hi_q <= prod_final[PW-1:WIDTH];
                        done_q   <= req_onehot(owner_q);
                    end
                end
                default: ;
            endcase
        end
    end

    assign oGrant      = grant;
    assign oBusy       = (state_q != ST_IDLE);
    assign oOwner      = owner_q;
    assign oDone       = done_q;
    assign oResultLow  = res_lo_q;
    assign oResultHigh = res_hi_q;

endmodule

// File: tb/tb_mul_sequencer.sv
// Self-checking bench for mul_sequencer: directed cases plus randomized
// traffic from both requesters, checked every cycle against a timing model.
module tb_mul_sequencer;

    localparam int unsigned W = 16;

    logic          Clock = 1'b0;
    logic          Reset = 1'b1;
    logic [1:0]    iReq, iSigned;
    logic [W-1:0]  iOpA0, iOpB0, iOpA1, iOpB1;
    logic [1:0]    oGrant, oDone;
    logic          oBusy, oOwner;
    logic [W-1:0]  oResultLow, oResultHigh;

    logic          req_v [2];
    logic          sgn_v [2];
    logic [W-1:0]  a_v   [2];
    logic [W-1:0]  b_v   [2];

    assign iReq    = {req_v[1], req_v[0]};
    assign iSigned = {sgn_v[1], sgn_v[0]};
    assign iOpA0   = a_v[0];
    assign iOpB0   = b_v[0];
    assign iOpA1   = a_v[1];
    assign iOpB1   = b_v[1];

    int n_checks = 0;
    int n_fail   = 0;

    mul_sequencer #(.WIDTH(W)) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .iReq        (iReq),
        .iSigned     (iSigned),
        .iOpA0       (iOpA0),
        .iOpB0       (iOpB0),
        .iOpA1       (iOpA1),
        .iOpB1       (iOpB1),
        .oGrant      (oGrant),
        .oBusy       (oBusy),
        .oOwner      (oOwner),
        .oDone       (oDone),
        .oResultLow  (oResultLow),
        .oResultHigh (oResultHigh)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference product: extend each operand by its signedness, multiply, keep 2W bits.
    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        longint sa, sb, p;
        sa = s ? longint'($signed(a)) : longint'(a);
        sb = s ? longint'($signed(b)) : longint'(b);
        p  = sa * sb;
        return p[2*W-1:0];
    endfunction

    function automatic logic [1:0] ref_arb(input logic [1:0] r, input logic last);
        if (r == 2'b11) return last ? 2'b01 : 2'b10;
        return r;
    endfunction

    function automatic logic [W-1:0] pick_op();
        case ($urandom_range(0, 7))
            0: return 16'h0000;
            1: return 16'h0001;
            2: return 16'h8000;
            3: return 16'hFFFF;
            4: return 16'h7FFF;
            default: return W'($urandom);
        endcase
    endfunction

    // Model: a granted op keeps the engine busy for W+1 cycles; done shows in the last one.
    bit            m_valid = 1'b0;
    int            m_left  = 0;
    logic          m_last  = 1'b1;
    logic          m_owner = 1'b0;
    logic [2*W-1:0] m_prod = '0;
    logic [2*W-1:0] m_res  = '0;

    // Per-cycle comparison against the model, then advance the model across the next edge.
    always @(negedge Clock) begin
        logic [1:0] eg;
        logic       gi;
        eg = (m_left == 0) ? ref_arb(iReq, m_last) : 2'b00;
        if (m_valid) begin
            check("grant", 64'(oGrant), 64'(eg));
            check("busy", 64'(oBusy), 64'(m_left != 0));
            check("owner", 64'(oOwner), 64'(m_owner));
            check("done", 64'(oDone), (m_left == 1) ? (m_owner ? 64'd2 : 64'd1) : 64'd0);
            check("res_low", 64'(oResultLow), 64'(m_res[W-1:0]));
            check("res_high", 64'(oResultHigh), 64'(m_res[2*W-1:W]));
        end
        if (Reset) begin
            m_valid = 1'b1;
            m_left  = 0;
            m_last  = 1'b1;
            m_owner = 1'b0;
            m_res   = '0;
        end else if (m_valid) begin
            if (m_left == 0) begin
                if (eg != 2'b00) begin
                    gi      = eg[1];
                    m_owner = gi;
                    m_last  = gi;
                    m_prod  = ref_mul(a_v[gi], b_v[gi], sgn_v[gi]);
                    m_left  = W + 1;
                end
            end else begin
                if (m_left == 2) m_res = m_prod;
                m_left--;
            end
        end
    end

    task automatic wait_grant(input int r, input string name);
        bit got;
        got = 1'b0;
        for (int t = 0; t < 100 && !got; t++) begin
            @(negedge Clock);
            if (oGrant[r]) got = 1'b1;
        end
        check({name, "_grant"}, 64'(oGrant), r ? 64'd2 : 64'd1);
    endtask

    // Issue one op from requester r and pin grant, latency and result to literals.
    task automatic run_op(input int r, input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                          input logic [2*W-1:0] exp, input logic [W-1:0] poke_a, input bit poke,
                          input string name);
        int n;
        @(posedge Clock); #1;
        a_v[r] = a; b_v[r] = b; sgn_v[r] = s; req_v[r] = 1'b1;
        wait_grant(r, name);
        @(posedge Clock); #1;
        req_v[r] = 1'b0;
        n = 0;
        for (int t = 0; t < 40; t++) begin
            @(negedge Clock);
            n++;
            if (n == 2 && poke) a_v[r] = poke_a;
            if (oDone != 2'b00) break;
        end
        check({name, "_latency"}, 64'(n), 64'd17);
        check({name, "_done"}, 64'(oDone), r ? 64'd2 : 64'd1);
        check({name, "_high"}, 64'(oResultHigh), 64'(exp[2*W-1:W]));
        check({name, "_low"}, 64'(oResultLow), 64'(exp[W-1:0]));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int done_cnt, busy_cnt;
        logic [1:0] g;
        int issued [2];
        for (int r = 0; r < 2; r++) begin
            req_v[r] = 1'b0; sgn_v[r] = 1'b0; a_v[r] = '0; b_v[r] = '0;
            issued[r] = 0;
        end
        repeat (3) @(posedge Clock);
        #1 Reset = 1'b0;

        @(negedge Clock);
        check("rst_busy", 64'(oBusy), 64'd0);
        check("rst_done", 64'(oDone), 64'd0);
        check("rst_owner", 64'(oOwner), 64'd0);
        check("rst_res", 64'({oResultHigh, oResultLow}), 64'd0);

        run_op(0, 16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE_0001, '0, 1'b0, "unsigned_max");
        run_op(1, 16'h8000, 16'h8000, 1'b1, 32'h4000_0000, '0, 1'b0, "signed_min");
        run_op(1, 16'hFFFF, 16'h0001, 1'b1, 32'hFFFF_FFFF, '0, 1'b0, "signed_m1");
        run_op(0, 16'h1234, 16'h0000, 1'b0, 32'h0000_0000, '0, 1'b0, "zero_b");
        run_op(0, 16'd3, 16'd5, 1'b0, 32'd15, 16'd9, 1'b1, "operand_hold");

        // Idle with no requests: nothing may happen.
        done_cnt = 0; busy_cnt = 0;
        for (int t = 0; t < 50; t++) begin
            @(negedge Clock);
            if (oDone != 2'b00) done_cnt++;
            if (oBusy) busy_cnt++;
        end
        check("idle_done", 64'(done_cnt), 64'd0);
        check("idle_busy", 64'(busy_cnt), 64'd0);

        // Tie: both held; last served was requester 0, so 10,01,10,01.
        @(posedge Clock); #1;
        a_v[0] = 16'd2; b_v[0] = 16'd3; sgn_v[0] = 1'b0;
        a_v[1] = 16'd7; b_v[1] = 16'd11; sgn_v[1] = 1'b0;
        req_v[0] = 1'b1; req_v[1] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            bit got;
            got = 1'b0;
            for (int t = 0; t < 60 && !got; t++) begin
                @(negedge Clock);
                if (oGrant != 2'b00) got = 1'b1;
            end
            check($sformatf("tie_grant%0d", k), 64'(oGrant), (k % 2 == 0) ? 64'd2 : 64'd1);
        end
        @(posedge Clock); #1;
        req_v[0] = 1'b0; req_v[1] = 1'b0;
        repeat (20) @(negedge Clock);

        // After reset the pointer favours requester 0 again.
        @(posedge Clock); #1;
        a_v[0] = 16'h1111; b_v[0] = 16'h2222; sgn_v[0] = 1'b0; req_v[0] = 1'b1;
        wait_grant(0, "abort");
        @(posedge Clock); #1;
        req_v[0] = 1'b0;
        repeat (8) @(posedge Clock);
        #1 Reset = 1'b1;
        @(posedge Clock); #1 Reset = 1'b0;
        @(negedge Clock);
        check("abort_res", 64'({oResultHigh, oResultLow}), 64'd0);
        check("abort_busy", 64'(oBusy), 64'd0);
        done_cnt = 0;
        for (int t = 0; t < 30; t++) begin
            @(negedge Clock);
            if (oDone != 2'b00) done_cnt++;
        end
        check("abort_no_done", 64'(done_cnt), 64'd0);
        @(posedge Clock); #1;
        a_v[0] = 16'd6; b_v[0] = 16'd7; req_v[0] = 1'b1;
        a_v[1] = 16'd8; b_v[1] = 16'd9; req_v[1] = 1'b1;
        @(negedge Clock);
        check("abort_first_grant", 64'(oGrant), 64'd1);
        @(posedge Clock); #1;
        req_v[0] = 1'b0; req_v[1] = 1'b0;
        repeat (20) @(negedge Clock);

        // Randomized traffic from both requesters.
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge Clock);
            g = oGrant;
            @(posedge Clock); #1;
            for (int r = 0; r < 2; r++) begin
                if (g[r]) begin
                    issued[r]++;
                    if (issued[r] < 60 && $urandom_range(0, 3) == 0) begin
                        a_v[r] = pick_op(); b_v[r] = pick_op(); sgn_v[r] = 1'($urandom);
                    end else begin
                        req_v[r] = 1'b0;
                        a_v[r] = W'($urandom); b_v[r] = W'($urandom);
                    end
                end else if (!req_v[r] && issued[r] < 60 && $urandom_range(0, 7) == 0) begin
                    a_v[r] = pick_op(); b_v[r] = pick_op(); sgn_v[r] = 1'($urandom);
                    req_v[r] = 1'b1;
                end else if (req_v[r] && $urandom_range(0, 31) == 0) begin
                    req_v[r] = 1'b0;
                end
            end
        end
        req_v[0] = 1'b0; req_v[1] = 1'b0;
        repeat (40) @(negedge Clock);
        check("random_ops_issued", 64'(issued[0] > 10 && issued[1] > 10), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
